message_scroll_mem: RTL and testbench

MESSAGE_SCROLL_MEM -- requirements
Module: message_scroll_mem

---
 rtl/message_scroll_mem.sv | 130 +++++++++++++
 tb/tb_message_scroll_mem.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/message_scroll_mem.sv
// Scrolling message memory: a DEPTH-character store viewed through a WIN-character window that advances on step or auto-timer.
// Optional macro MSG_MEM_WRITE_EN enables run-time character writes; otherwise the memory keeps its reset pattern.
module message_scroll_mem #(
  parameter int CHAR_W = 4,
  parameter int DEPTH  = 16,
  parameter int WIN    = 4,
  parameter int DIV    = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic                       auto_en,
  input  logic                       dir,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [CHAR_W-1:0]          wr_data,
  output logic [DEPTH*CHAR_W-1:0]    message,
  output logic [WIN*CHAR_W-1:0]      window,
  output logic [$clog2(DEPTH)-1:0]   ptr,
  output logic                       wrap
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TC_W    = TW'(DIV - 1);

  logic [CHAR_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     ptr_r;
  logic [AW-1:0]     ptr_nxt_s;
  logic              wrap_r;
  logic              wrap_nxt_s;
  logic [TW-1:0]     timer_r;
  logic              tc_s;
  logic              advance_s;

  assign tc_s      = auto_en && (timer_r == TC_W);
  assign advance_s = step || tc_s;

  // Auto-scroll timer: free-runs 0..DIV-1 while enabled, parked at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_r <= '0;
    end else if (!auto_en || tc_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Next window start and wrap flag for the requested direction.
  always_comb begin
    ptr_nxt_s  = ptr_r;
    wrap_nxt_s = 1'b0;
    if (advance_s) begin
      if (dir) begin
        if (ptr_r == '0) begin
          ptr_nxt_s  = LAST_W;
          wrap_nxt_s = 1'b1;
        end else begin
          ptr_nxt_s  = ptr_r - AW'(1);
        end
      end else begin
        if (ptr_r == LAST_W) begin
          ptr_nxt_s  = '0;
          wrap_nxt_s = 1'b1;
        end else begin
          ptr_nxt_s  = ptr_r + AW'(1);
        end
      end
    end else begin
      ptr_nxt_s  = ptr_r;
    end
  end

  // Window start pointer and single-cycle wrap pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r  <= '0;
      wrap_r <= 1'b0;
    end else begin
      ptr_r  <= ptr_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  // Character store: reset loads the index pattern, writes are optional.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= CHAR_W'(i);
      end
    end else begin
`ifdef MSG_MEM_WRITE_EN
      if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
        mem_r[wr_addr] <= wr_data;
      end
`endif
    end
  end

`ifndef MSG_MEM_WRITE_EN
  logic unused_wr_s;
  assign unused_wr_s = ^{wr_en, wr_addr, wr_data};
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_msg
    assign message[i*CHAR_W +: CHAR_W] = mem_r[i];
  end

  for (genvar k = 0; k < WIN; k++) begin : g_win
    logic [AW:0]   sum_s;
    logic [AW-1:0] idx_s;
    // Window slot index, folded back into 0..DEPTH-1.
    always_comb begin
      sum_s = {1'b0, ptr_r} + (AW + 1)'(k);
      if (sum_s >= DEPTH_W) begin
        idx_s = AW'(sum_s - DEPTH_W);
      end else begin
        idx_s = sum_s[AW-1:0];
      end
    end
    assign window[k*CHAR_W +: CHAR_W] = mem_r[idx_s];
  end

  assign ptr  = ptr_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_message_scroll_mem.sv
// Randomized self-checking bench for message_scroll_mem against a behavioural model of the scroll memory.
// Honours MSG_MEM_WRITE_EN the same way the design does.
module tb_message_scroll_mem;

  localparam int CW = 4;
  localparam int D  = 16;
  localparam int W  = 4;
  localparam int DV = 4;

  logic          clk;
  logic          reset;
  logic          step;
  logic          auto_en;
  logic          dir;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic [D*CW-1:0] message;
  logic [W*CW-1:0] window;
  logic [3:0]    ptr;
  logic          wrap;

  int n_checks = 0;
  int n_errors = 0;

  int mem_m [D];
  int ptr_m;
  int wrap_m;
  int run_len;

  message_scroll_mem #(.CHAR_W(CW), .DEPTH(D), .WIN(W), .DIV(DV)) dut (
    .clk(clk), .reset(reset), .step(step), .auto_en(auto_en), .dir(dir),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .message(message), .window(window), .ptr(ptr), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) mem_m[i] = i % (1 << CW);
    ptr_m   = 0;
    wrap_m  = 0;
    run_len = 0;
  endtask

  task automatic model_cycle(input logic s, input logic a, input logic d, input logic we,
                             input logic [3:0] wa, input logic [CW-1:0] wd);
    bit adv;
    adv = s || (a && (run_len % DV) == DV - 1);
    run_len = a ? run_len + 1 : 0;
`ifdef MSG_MEM_WRITE_EN
    if (we && int'(wa) < D) mem_m[wa] = int'(wd);
`endif
    wrap_m = 0;
    if (adv) begin
      if (d) begin
        wrap_m = (ptr_m == 0);
        ptr_m  = (ptr_m + D - 1) % D;
      end else begin
        wrap_m = (ptr_m == D - 1);
        ptr_m  = (ptr_m + 1) % D;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [63:0] exp_msg;
    logic [63:0] exp_win;
    exp_msg = '0;
    exp_win = '0;
    for (int i = 0; i < D; i++) exp_msg[i*CW +: CW] = CW'(mem_m[i]);
    for (int k = 0; k < W; k++) exp_win[k*CW +: CW] = CW'(mem_m[(ptr_m + k) % D]);
    check({tag, ".message"}, 64'(message), exp_msg);
    check({tag, ".window"}, 64'(window), exp_win);
    check({tag, ".ptr"}, 64'(ptr), 64'(ptr_m));
    check({tag, ".wrap"}, 64'(wrap), 64'(wrap_m));
  endtask

  // Called at posedge+1: drives inputs, waits one edge, updates model, compares.
  task automatic cycle(input logic s, input logic a, input logic d, input logic we,
                       input logic [3:0] wa, input logic [CW-1:0] wd);
    step = s; auto_en = a; dir = d; wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk);
    model_cycle(s, a, d, we, wa, wd);
    #1;
    compare_all("cyc");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_message", 64'(message), 64'hFEDCBA9876543210);
    check("rst_window", 64'(window), 64'h3210);
    check("rst_ptr", 64'(ptr), 64'h0);
    check("rst_wrap", 64'(wrap), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all("post_rst");
  endtask

  initial begin
    int base;
    reset = 1'b1; step = 1'b0; auto_en = 1'b0; dir = 1'b0;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = '0;
    do_reset();

    // Forward steps through the end of the memory.
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check("fwd15_ptr", 64'(ptr), 64'd15);
    check("fwd15_window", 64'(window), 64'h210F);
    check("fwd15_wrap", 64'(wrap), 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check("fwd16_ptr", 64'(ptr), 64'd0);
    check("fwd16_wrap", 64'(wrap), 64'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    check("wrap_one_cycle", 64'(wrap), 64'h0);

    // Backward step from zero.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    check("bwd_ptr", 64'(ptr), 64'd15);
    check("bwd_wrap", 64'(wrap), 64'h1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Auto-scroll: 12 enabled cycles with DIV=4 give three advances.
    base = int'(ptr);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check("auto12_adv", 64'((int'(ptr) - base + D) % D), 64'd3);
    base = int'(ptr);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check("step_tc_single", 64'((int'(ptr) - base + D) % D), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

    // Write and advance in the same cycle.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 4'hA);
    check("wr_step_ptr", 64'(ptr), 64'd1);
`ifdef MSG_MEM_WRITE_EN
    check("wr_step_window", 64'(window), 64'h432A);
`else
    check("wr_step_window", 64'(window), 64'h4321);
`endif

    // Reset in the middle of auto-scroll at ptr=7, then timer restarts from zero.
    do_reset();
    for (int i = 0; i < 28; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'(i), 4'(i + 3));
    check("auto_ptr7", 64'(ptr), 64'd7);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    check("post_rst_auto", 64'(ptr), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), CW'($urandom_range(0, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
